// File: rtl/comparator.sv
// comparator: registered magnitude/relation flags for two N-bit operands.
// Flag map of y: [0] eq, [1] ne, [2] gtu, [3] ltu, [4] geu, [5] leu,
// [6] gts (signed a > b), [7] lts (signed a < b).
// One cycle of latency; y holds its last value while in_valid is low.
module comparator #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [7:0]   y,
    output logic         out_valid
);

    logic [N:0]   diff;
    logic         eq, ltu, gtu;
    logic         sign_diff;
    logic         gts, lts;
    logic [7:0]   y_d, y_q;
    logic         out_valid_q;

    // Flag logic: full N+1-bit subtract so the borrow is correct even when
    // the operands are more than 2^(N-1) apart; signed compare only differs
    // from unsigned when the sign bits disagree.
    always_comb begin
        diff      = {1'b0, a} - {1'b0, b};
        eq        = (a == b);
        ltu       = diff[N];
        gtu       = ~ltu & ~eq;
        sign_diff = a[N-1] ^ b[N-1];
        gts       = sign_diff ? ~a[N-1] : gtu;
        lts       = sign_diff ?  a[N-1] : ltu;
        y_d       = {lts, gts, ltu | eq, gtu | eq, ltu, gtu, ~eq, eq};
    end

    // Result registers: capture on in_valid, otherwise hold y and drop out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                y_q <= y_d;
            end
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_comparator.sv
// tb_comparator: directed plus exhaustive and random checks of comparator
// (N = 4) against an arithmetic reference model.
module tb_comparator;

    localparam int N    = 4;
    localparam int FULL = 1 << N;
    localparam int HALF = 1 << (N - 1);

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [7:0]   y;
    logic         out_valid;

    int n_cmp;
    int n_bad;
    logic [7:0] exp_y;

    comparator #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .y         (y),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integers, ordinary comparisons, two's complement by offset.
    function automatic logic [7:0] ref_flags(int ua, int ub);
        int sa, sb;
        logic [7:0] f;
        sa = (ua >= HALF) ? ua - FULL : ua;
        sb = (ub >= HALF) ? ub - FULL : ub;
        f    = 8'h00;
        f[0] = (ua == ub);
        f[1] = (ua != ub);
        f[2] = (ua >  ub);
        f[3] = (ua <  ub);
        f[4] = (ua >= ub);
        f[5] = (ua <= ub);
        f[6] = (sa >  sb);
        f[7] = (sa <  sb);
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of input, then look just after the sampling edge.
    task automatic step(input logic v, input int ua, input int ub);
        in_valid = v;
        a        = ua[N-1:0];
        b        = ub[N-1:0];
        @(posedge clk);
        #1;
        if (v) exp_y = ref_flags(ua, ub);
    endtask

    task automatic check_result(input string tag, input logic v);
        chk({tag, "_y"},  {24'h0, y}, {24'h0, exp_y});
        chk({tag, "_ov"}, {31'h0, out_valid}, {31'h0, v});
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        exp_y    = 8'h00;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        a        = 4'h5;
        b        = 4'h3;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_y",  {24'h0, y}, 32'h0);
        chk("rst_async_ov", {31'h0, out_valid}, 32'h0);

        // Valid operands present while reset is held: nothing gets through.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_hold_y",  {24'h0, y}, 32'h0);
            chk("rst_hold_ov", {31'h0, out_valid}, 32'h0);
        end
        rst_n = 1'b1;
        step(1'b1, 5, 3);
        chk("rst_first_y", {24'h0, y}, 32'h56);
        chk("rst_first_ov", {31'h0, out_valid}, 32'h1);

        // Directed corner cases with hand-derived flag values.
        step(1'b1, 9, 9);    chk("eq_y",    {24'h0, y}, 32'h31);
        step(1'b1, 15, 0);   chk("gapF0_y", {24'h0, y}, 32'h96);
        step(1'b1, 0, 15);   chk("gap0F_y", {24'h0, y}, 32'h6A);
        step(1'b1, 7, 8);    chk("sgn78_y", {24'h0, y}, 32'h6A);
        step(1'b1, 8, 7);    chk("sgn87_y", {24'h0, y}, 32'h96);
        chk("sgn87_ov", {31'h0, out_valid}, 32'h1);

        // Exhaustive sweep, back to back, with one idle cycle in the middle.
        for (int i = 0; i < FULL * FULL; i++) begin
            if (i == 100) begin
                step(1'b0, 3, 12);
                check_result("idle", 1'b0);
            end
            step(1'b1, i / FULL, i % FULL);
            check_result("sweep", 1'b1);
            // Invariants checked directly on the DUT flags.
            chk("inv_onehot", {30'h0, 2'(y[0] + y[2] + y[3])}, 32'h1);
            chk("inv_ne",  {31'h0, y[1]}, {31'h0, ~y[0]});
            chk("inv_geu", {31'h0, y[4]}, {31'h0, y[2] | y[0]});
            chk("inv_leu", {31'h0, y[5]}, {31'h0, y[3] | y[0]});
            chk("inv_sgn", {31'h0, ~(y[6] | y[7])}, {31'h0, y[0]});
        end

        // Random stream with random valid gaps.
        for (int i = 0; i < 300; i++) begin
            logic v;
            v = 1'($urandom_range(0, 3) != 0);
            step(v, int'($urandom_range(0, FULL - 1)), int'($urandom_range(0, FULL - 1)));
            check_result("rand", v);
        end

        // Reset between edges while a result is pending.
        step(1'b1, 2, 11);
        check_result("pre_rst", 1'b1);
        in_valid = 1'b1; a = 4'h4; b = 4'h1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_y",  {24'h0, y}, 32'h0);
        chk("midrst_ov", {31'h0, out_valid}, 32'h0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        exp_y = 8'h00;
        step(1'b0, 4, 1);
        check_result("post_rst_idle", 1'b0);
        step(1'b1, 4, 1);
        check_result("post_rst_valid", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
